// File: rtl/y86_fetch_pc.sv
// y86 fetch-stage program counter: PC register, fall-through address,
// redirect/stall handling, sticky processor status and retired count.
module y86_fetch_pc #(
  parameter int                ADDR_W     = 32,
  parameter int                VALC_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                MEM_BYTES  = 4096,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              need_regids,
  input  logic              need_valC,
  input  logic              is_halt,
  input  logic              instr_invalid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] valP,
  output logic [2:0]        stat,
  output logic              fetch_en,
  output logic [CNT_W-1:0]  icount
);

  typedef enum logic [2:0] {
    S_RUN = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } state_e;

  localparam int          AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0] MEM_LIM = AW1'(MEM_BYTES);
  localparam logic [AW1-1:0] VC_LEN  = AW1'(VALC_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [AW1-1:0]    len;
  logic [AW1-1:0]    end_addr;
  logic              adr_fault;
  logic              run;

  // Instruction length and end address, one extra bit so wrap is visible
  always_comb begin
    len       = AW1'(1) + AW1'(need_regids)
              + (need_valC ? VC_LEN : '0);
    end_addr  = {1'b0, pc_q} + len;
    adr_fault = end_addr > MEM_LIM;
    run       = (state_q == S_RUN);
    valP      = run ? end_addr[ADDR_W-1:0] : pc_q;
  end

  // Next PC, state and count; redirect beats everything in RUN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (run) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (instr_valid && instr_invalid) begin
        state_d = S_INS;
      end else if (instr_valid && adr_fault) begin
        state_d = S_ADR;
      end else if (instr_valid && is_halt) begin
        state_d = S_HLT;
        cnt_d   = cnt_q + CNT_W'(1);
      end else if (instr_valid) begin
        pc_d  = valP;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc       = pc_q;
  assign stat     = state_q;
  assign fetch_en = (state_q == S_RUN);
  assign icount   = cnt_q;

endmodule

// File: tb/tb_y86_fetch_pc.sv
// Bench for y86_fetch_pc: scenario tasks push expected PC/status/count
// into a scoreboard queue and compare after each clock edge.
module tb_y86_fetch_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, stall, need_regids, need_valC;
  logic        is_halt, instr_invalid, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc, valP, icount;
  logic [2:0]  stat;
  logic        fetch_en;
  logic [7:0]  pc8, valP8;
  logic [2:0]  stat8;
  logic        fetch_en8;
  logic [31:0] icount8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  stat;
    logic [31:0] cnt;
    logic        fen;
  } exp_t;

  typedef struct {
    logic        rst, v, st, rg, vc, h, inv, rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [2:0]  est;
    logic [31:0] ecnt;
  } row_t;

  exp_t q[$];

  always #5 clk = ~clk;

  y86_fetch_pc dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .stall(stall), .need_regids(need_regids), .need_valC(need_valC),
    .is_halt(is_halt), .instr_invalid(instr_invalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .valP(valP), .stat(stat), .fetch_en(fetch_en),
    .icount(icount)
  );

  y86_fetch_pc #(.ADDR_W(8), .MEM_BYTES(256)) dut8 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .stall(stall), .need_regids(need_regids), .need_valC(need_valC),
    .is_halt(is_halt), .instr_invalid(instr_invalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[7:0]),
    .pc(pc8), .valP(valP8), .stat(stat8), .fetch_en(fetch_en8),
    .icount(icount8)
  );

  task automatic drive(input row_t r);
    reset          = r.rst;
    instr_valid    = r.v;
    stall          = r.st;
    need_regids    = r.rg;
    need_valC      = r.vc;
    is_halt        = r.h;
    instr_invalid  = r.inv;
    redirect_valid = r.rv;
    redirect_pc    = r.rpc;
  endtask

  task automatic apply(input row_t r);
    drive(r);
    q.push_back('{r.epc, r.est, r.ecnt, (r.est == 3'd1)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply('{1,1,1,1,1,1,1,1,32'h55, 32'h0,3'd1,32'd0});
    e = q.pop_front();
    checks++;
    if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
      errors++;
      $display("FAIL reset: pc=%h stat=%0d cnt=%0d fen=%b want pc=%h stat=%0d cnt=%0d fen=%b",
               pc, stat, icount, fetch_en, e.pc, e.stat, e.cnt, e.fen);
    end
    checks++;
    if (valP !== 32'd6) begin
      errors++;
      $display("FAIL reset_valP: got %h want 6", valP);
    end
  endtask

  task automatic test_len_mix();
    row_t t[4];
    exp_t e;
    t[0] = '{0,1,0,0,0,0,0,0,32'h0, 32'd1, 3'd1,32'd1};
    t[1] = '{0,1,0,1,0,0,0,0,32'h0, 32'd3, 3'd1,32'd2};
    t[2] = '{0,1,0,1,1,0,0,0,32'h0, 32'd9, 3'd1,32'd3};
    t[3] = '{0,1,0,0,1,0,0,0,32'h0, 32'd14,3'd1,32'd4};
    for (int i = 0; i < 4; i++) begin
      drive(t[i]);
      #1;
      checks++;
      if (valP !== t[i].epc) begin
        errors++;
        $display("FAIL len_valP[%0d]: got %h want %h", i, valP, t[i].epc);
      end
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL len_mix[%0d]: pc=%h stat=%0d cnt=%0d want pc=%h stat=%0d cnt=%0d",
                 i, pc, stat, icount, e.pc, e.stat, e.cnt);
      end
    end
  endtask

  task automatic test_stall_redirect();
    row_t t[5];
    exp_t e;
    t[0] = '{0,0,0,0,0,0,0,1,32'h20,  32'h20, 3'd1,32'd4};
    t[1] = '{0,1,1,1,1,0,0,0,32'h0,   32'h20, 3'd1,32'd4};
    t[2] = '{0,1,1,0,0,1,0,0,32'h0,   32'h20, 3'd1,32'd4};
    t[3] = '{0,1,1,1,0,0,1,0,32'h0,   32'h20, 3'd1,32'd4};
    t[4] = '{0,1,1,0,0,0,0,1,32'h100, 32'h100,3'd1,32'd4};
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL stall_redir[%0d]: pc=%h stat=%0d cnt=%0d want pc=%h stat=%0d cnt=%0d",
                 i, pc, stat, icount, e.pc, e.stat, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    row_t t[6];
    exp_t e;
    t[0] = '{0,0,0,0,0,0,0,1,32'h40, 32'h40,3'd1,32'd4};
    t[1] = '{0,1,0,0,0,1,0,0,32'h0,  32'h40,3'd2,32'd5};
    t[2] = '{0,0,0,0,1,0,0,1,32'h80, 32'h40,3'd2,32'd5};
    t[3] = '{0,1,0,1,1,0,0,0,32'h0,  32'h40,3'd2,32'd5};
    t[4] = '{0,0,0,0,0,0,0,1,32'h90, 32'h40,3'd2,32'd5};
    t[5] = '{0,1,0,0,1,1,1,1,32'h0,  32'h40,3'd2,32'd5};
    for (int i = 0; i < 6; i++) begin
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL halt[%0d]: pc=%h stat=%0d cnt=%0d fen=%b want pc=%h stat=%0d cnt=%0d fen=%b",
                 i, pc, stat, icount, fetch_en, e.pc, e.stat, e.cnt, e.fen);
      end
      if (i >= 1) begin
        checks++;
        if (valP !== 32'h40) begin
          errors++;
          $display("FAIL halt_valP[%0d]: got %h want 40", i, valP);
        end
      end
    end
  endtask

  task automatic test_boundary();
    row_t t[6];
    exp_t e;
    t[0] = '{1,0,0,0,0,0,0,0,32'h0,   32'h0,   3'd1,32'd0};
    t[1] = '{0,0,0,0,0,0,0,1,32'hFFA, 32'hFFA, 3'd1,32'd0};
    t[2] = '{0,1,0,1,1,0,0,0,32'h0,   32'h1000,3'd1,32'd1};
    t[3] = '{0,0,0,0,0,0,0,1,32'hFFB, 32'hFFB, 3'd1,32'd1};
    t[4] = '{0,1,0,1,1,0,0,0,32'h0,   32'hFFB, 3'd3,32'd1};
    t[5] = '{0,1,0,0,0,0,0,0,32'h0,   32'hFFB, 3'd3,32'd1};
    for (int i = 0; i < 6; i++) begin
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL boundary[%0d]: pc=%h stat=%0d cnt=%0d fen=%b want pc=%h stat=%0d cnt=%0d fen=%b",
                 i, pc, stat, icount, fetch_en, e.pc, e.stat, e.cnt, e.fen);
      end
    end
  endtask

  task automatic test_invalid();
    row_t t[5];
    exp_t e;
    t[0] = '{1,0,0,0,0,0,0,0,32'h0,   32'h0,  3'd1,32'd0};
    t[1] = '{0,0,0,0,0,0,0,1,32'hFFE, 32'hFFE,3'd1,32'd0};
    t[2] = '{0,1,0,0,1,0,1,0,32'h0,   32'hFFE,3'd4,32'd0};
    t[3] = '{1,1,0,1,1,1,1,1,32'h77,  32'h0,  3'd1,32'd0};
    t[4] = '{0,1,0,1,0,0,0,0,32'h0,   32'h2,  3'd1,32'd1};
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL invalid[%0d]: pc=%h stat=%0d cnt=%0d want pc=%h stat=%0d cnt=%0d",
                 i, pc, stat, icount, e.pc, e.stat, e.cnt);
      end
    end
  endtask

  task automatic test_redirect_vs_halt();
    row_t t[4];
    exp_t e;
    t[0] = '{1,0,0,0,0,0,0,0,32'h0,  32'h0, 3'd1,32'd0};
    t[1] = '{0,1,0,0,0,0,0,0,32'h0,  32'h1, 3'd1,32'd1};
    t[2] = '{0,1,0,0,0,1,0,1,32'h10, 32'h10,3'd1,32'd1};
    t[3] = '{0,1,0,0,0,0,0,0,32'h0,  32'h11,3'd1,32'd2};
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({pc,stat,icount,fetch_en} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL redir_halt[%0d]: pc=%h stat=%0d cnt=%0d want pc=%h stat=%0d cnt=%0d",
                 i, pc, stat, icount, e.pc, e.stat, e.cnt);
      end
    end
  endtask

  task automatic test_wrap8();
    row_t t[3];
    exp_t e;
    t[0] = '{1,0,0,0,0,0,0,0,32'h0,  32'h0, 3'd1,32'd0};
    t[1] = '{0,0,0,0,0,0,0,1,32'hFF, 32'hFF,3'd1,32'd0};
    t[2] = '{0,1,0,1,0,0,0,0,32'h0,  32'hFF,3'd3,32'd0};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        drive(t[i]);
        #1;
        checks++;
        if (valP8 !== 8'h01) begin
          errors++;
          $display("FAIL wrap8_valP: got %h want 01", valP8);
        end
      end
      apply(t[i]);
      e = q.pop_front();
      checks++;
      if ({24'h0,pc8,stat8,icount8,fetch_en8} !== {e.pc,e.stat,e.cnt,e.fen}) begin
        errors++;
        $display("FAIL wrap8[%0d]: pc=%h stat=%0d cnt=%0d want pc=%h stat=%0d cnt=%0d",
                 i, pc8, stat8, icount8, e.pc, e.stat, e.cnt);
      end
    end
  endtask

  initial begin
    drive('{1,0,0,0,0,0,0,0,32'h0, 32'h0,3'd1,32'd0});
    @(posedge clk);
    #1;
    test_reset();
    test_len_mix();
    test_stall_redirect();
    test_halt();
    test_boundary();
    test_invalid();
    test_redirect_vs_halt();
    test_wrap8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
